// File: rtl/cam_update_ctrl_if.sv
// Request/response channel between a command source and cam_update_ctrl.
// The master issues lookup/insert/delete commands; the slave answers each one.
interface cam_update_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_key;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] resp_addr;

  // Command source side
  modport master (
    output req_valid, req_op, req_key, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_err, resp_addr
  );

  // Controller side
  modport slave (
    input  req_valid, req_op, req_key, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_err, resp_addr
  );
endinterface

// File: rtl/cam_update_ctrl.sv
// Command front-end for an SRL-based CAM: runs one lookup/insert/delete at a
// time, keeps the entry-valid bitmap and occupancy count, allocates the lowest
// free row on insert and turns delete-by-key into a delete-by-address.
module cam_update_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cam_update_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ENTRIES_CNT = ENTRIES[ADDR_WIDTH:0];

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_EVAL,
    S_WRITE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  del_q, del_d;
  logic [ENTRIES-1:0]    bitmap_q, bitmap_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  // Low while reset is held so req_ready reads 0 during reset regardless of busy.
  logic                  run_q;

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  req_ready_c;
  logic                  write_en_c;
  logic                  full_c;

  assign full_c = (occ_q == ENTRIES_CNT);

  // Lowest-index clear bit of the valid bitmap (scan high to low, last wins).
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) begin
        free_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    hit_d       = hit_q;
    err_d       = err_q;
    addr_d      = addr_q;
    del_d       = del_q;
    bitmap_d    = bitmap_q;
    occ_d       = occ_q;
    req_ready_c = 1'b0;
    write_en_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // CAM is busy while it clears itself after reset; hold off until done.
        req_ready_c = run_q && !cam_write_busy;
        if (bus.req_valid && req_ready_c) begin
          op_d    = bus.req_op;
          key_d   = bus.req_key;
          state_d = S_SEARCH;
        end
      end

      // The CAM match output is registered; give it one cycle on the new key.
      S_SEARCH: state_d = S_EVAL;

      S_EVAL: begin
        hit_d  = 1'b0;
        err_d  = 1'b0;
        addr_d = '0;
        del_d  = 1'b0;
        case (op_q)
          OP_LOOKUP: begin
            hit_d   = cam_match;
            addr_d  = cam_match ? cam_match_addr : '0;
            state_d = S_RESP;
          end
          OP_INSERT: begin
            if (cam_match) begin
              // Duplicate: report where it already lives, leave the CAM alone.
              hit_d   = 1'b1;
              addr_d  = cam_match_addr;
              state_d = S_RESP;
            end else if (full_c) begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end else begin
              addr_d  = free_idx;
              state_d = S_WRITE;
            end
          end
          OP_DELETE: begin
            if (cam_match) begin
              hit_d   = 1'b1;
              addr_d  = cam_match_addr;
              del_d   = 1'b1;
              state_d = S_WRITE;
            end else begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        endcase
      end

      S_WRITE: begin
        // Busy is already low here; the guard keeps enable off a busy CAM.
        if (!cam_write_busy) begin
          write_en_c = 1'b1;
          if (del_q) begin
            bitmap_d[addr_q] = 1'b0;
            occ_d            = occ_q - 1'b1;
          end else begin
            bitmap_d[addr_q] = 1'b1;
            occ_d            = occ_q + 1'b1;
          end
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!cam_write_busy) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      key_q    <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      del_q    <= 1'b0;
      bitmap_q <= '0;
      occ_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      del_q    <= del_d;
      bitmap_q <= bitmap_d;
      occ_q    <= occ_d;
      run_q    <= 1'b1;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_hit   = hit_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_addr  = addr_q;

  assign cam_write_addr   = addr_q;
  assign cam_write_data   = key_q;
  assign cam_write_delete = del_q;
  assign cam_write_enable = write_en_c;
  assign cam_compare_data = key_q;

  assign occupancy = occ_q;
  assign full      = full_c;

endmodule
